// File: rtl/writeback_regfile_if.sv
// Bus between the memory stage and the write-back stage: the M-stage
// instruction fields and pipeline control going in, and the W pipeline
// register contents coming back out for decode forwarding.
interface writeback_regfile_if;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [63:0] M_valE;
    logic [63:0] m_valM;
    logic        W_stall;
    logic        W_bubble;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valE;
    logic [63:0] W_valM;

    // Memory-stage side: drives the instruction and control, sees W contents.
    modport master (
        output M_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM,
        output W_stall, W_bubble,
        input  W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM
    );

    // Write-back stage side.
    modport slave (
        input  M_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM,
        input  W_stall, W_bubble,
        output W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM
    );
endinterface

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, the 15 architectural
// registers, processor status and the retired-instruction counter.
// An instruction latched into W at one edge is committed at the next.
module writeback_regfile #(
    parameter logic [63:0] RSP_INIT = 64'h0,
    parameter logic [2:0]  S_BUB    = 3'd0,
    parameter logic [2:0]  S_AOK    = 3'd1,
    parameter logic [2:0]  S_HLT    = 3'd2,
    parameter logic [2:0]  S_ADR    = 3'd3,
    parameter logic [2:0]  S_INS    = 3'd4
) (
    input  logic                  clk,
    input  logic                  reset,
    writeback_regfile_if.slave    wb,
    output logic [63:0]           reg0,
    output logic [63:0]           reg1,
    output logic [63:0]           reg2,
    output logic [63:0]           reg3,
    output logic [63:0]           reg4,
    output logic [63:0]           reg5,
    output logic [63:0]           reg6,
    output logic [63:0]           reg7,
    output logic [63:0]           reg8,
    output logic [63:0]           reg9,
    output logic [63:0]           reg10,
    output logic [63:0]           reg11,
    output logic [63:0]           reg12,
    output logic [63:0]           reg13,
    output logic [63:0]           reg14,
    output logic [2:0]            stat,
    output logic                  halted,
    output logic [63:0]           retired
);

    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] REG_NONE  = 4'hF;

    logic [2:0]  w_stat_reg;
    logic [3:0]  w_icode_reg;
    logic [3:0]  w_dste_reg;
    logic [3:0]  w_dstm_reg;
    logic [63:0] w_vale_reg;
    logic [63:0] w_valm_reg;

    logic [2:0]  stat_reg;
    logic        halted_reg;
    logic [63:0] retired_reg;

    logic [63:0] reg_file [0:14];

    logic        commit_en;
    logic        halt_now;
    logic [2:0]  stat_next;

    // Only a live AOK instruction commits; any non-bubble, non-AOK status
    // stops the machine. Unknown codes 5..7 are reported as an illegal op.
    always_comb begin
        commit_en = (w_stat_reg == S_AOK) && !halted_reg;
        halt_now  = !halted_reg && (w_stat_reg != S_AOK) && (w_stat_reg != S_BUB);
        stat_next = S_INS;
        if ((w_stat_reg == S_HLT) || (w_stat_reg == S_ADR)) begin
            stat_next = w_stat_reg;
        end
    end

    // W pipeline register: frozen when halted, stall beats bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_stat_reg  <= S_BUB;
            w_icode_reg <= ICODE_NOP;
            w_dste_reg  <= REG_NONE;
            w_dstm_reg  <= REG_NONE;
            w_vale_reg  <= 64'd0;
            w_valm_reg  <= 64'd0;
        end else if (halted_reg || wb.W_stall) begin
            w_stat_reg  <= w_stat_reg;
        end else if (wb.W_bubble) begin
            w_stat_reg  <= S_BUB;
            w_icode_reg <= ICODE_NOP;
            w_dste_reg  <= REG_NONE;
            w_dstm_reg  <= REG_NONE;
            w_vale_reg  <= 64'd0;
            w_valm_reg  <= 64'd0;
        end else begin
            w_stat_reg  <= wb.M_stat;
            w_icode_reg <= wb.M_icode;
            w_dste_reg  <= wb.M_dstE;
            w_dstm_reg  <= wb.M_dstM;
            w_vale_reg  <= wb.M_valE;
            w_valm_reg  <= wb.m_valM;
        end
    end

    // One write process per architectural register; the M port takes
    // priority so popq %rsp leaves the popped value in %rsp.
    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_reg
            localparam logic [3:0] IDX = 4'(gi);
            always_ff @(posedge clk) begin
                if (reset) begin
                    reg_file[gi] <= (gi == 4) ? RSP_INIT : 64'd0;
                end else if (commit_en && (w_dstm_reg == IDX)) begin
                    reg_file[gi] <= w_valm_reg;
                end else if (commit_en && (w_dste_reg == IDX)) begin
                    reg_file[gi] <= w_vale_reg;
                end
            end
        end
    endgenerate

    // Status, sticky halt and retired count; a stalled instruction
    // re-commits and therefore counts again every cycle it is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reg    <= S_AOK;
            halted_reg  <= 1'b0;
            retired_reg <= 64'd0;
        end else if (halt_now) begin
            stat_reg    <= stat_next;
            halted_reg  <= 1'b1;
        end else if (commit_en) begin
            retired_reg <= retired_reg + 64'd1;
        end
    end

    assign wb.W_stat  = w_stat_reg;
    assign wb.W_icode = w_icode_reg;
    assign wb.W_dstE  = w_dste_reg;
    assign wb.W_dstM  = w_dstm_reg;
    assign wb.W_valE  = w_vale_reg;
    assign wb.W_valM  = w_valm_reg;

    assign stat    = stat_reg;
    assign halted  = halted_reg;
    assign retired = retired_reg;

    assign reg0  = reg_file[0];
    assign reg1  = reg_file[1];
    assign reg2  = reg_file[2];
    assign reg3  = reg_file[3];
    assign reg4  = reg_file[4];
    assign reg5  = reg_file[5];
    assign reg6  = reg_file[6];
    assign reg7  = reg_file[7];
    assign reg8  = reg_file[8];
    assign reg9  = reg_file[9];
    assign reg10 = reg_file[10];
    assign reg11 = reg_file[11];
    assign reg12 = reg_file[12];
    assign reg13 = reg_file[13];
    assign reg14 = reg_file[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: a directed vector table for the documented
// scenarios, then random traffic compared against a behavioural model.
module tb_writeback_regfile;

    localparam logic [63:0] RSP = 64'h100;

    logic clk;
    logic reset;
    logic [63:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
    logic [63:0] reg8, reg9, reg10, reg11, reg12, reg13, reg14;
    logic [2:0]  stat;
    logic        halted;
    logic [63:0] retired;
    logic [63:0] dut_regs [15];

    int errors = 0;
    int checks = 0;

    writeback_regfile_if wbif ();

    writeback_regfile #(.RSP_INIT(RSP)) dut (
        .clk(clk), .reset(reset), .wb(wbif.slave),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4),
        .reg5(reg5), .reg6(reg6), .reg7(reg7), .reg8(reg8), .reg9(reg9),
        .reg10(reg10), .reg11(reg11), .reg12(reg12), .reg13(reg13), .reg14(reg14),
        .stat(stat), .halted(halted), .retired(retired)
    );

    assign dut_regs[0]  = reg0;  assign dut_regs[1]  = reg1;  assign dut_regs[2]  = reg2;
    assign dut_regs[3]  = reg3;  assign dut_regs[4]  = reg4;  assign dut_regs[5]  = reg5;
    assign dut_regs[6]  = reg6;  assign dut_regs[7]  = reg7;  assign dut_regs[8]  = reg8;
    assign dut_regs[9]  = reg9;  assign dut_regs[10] = reg10; assign dut_regs[11] = reg11;
    assign dut_regs[12] = reg12; assign dut_regs[13] = reg13; assign dut_regs[14] = reg14;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: architectural registers plus the in-flight
    // W instruction, updated once per clock from the architectural rules.
    logic [63:0] m_regs [15];
    logic [2:0]  m_wstat;
    logic [3:0]  m_wicode, m_wdste, m_wdstm;
    logic [63:0] m_wvale, m_wvalm;
    logic [2:0]  m_stat;
    logic        m_halted;
    logic [63:0] m_retired;

    task automatic model_step(input logic rst, input logic stall, input logic bubble,
                              input logic [2:0] ms, input logic [3:0] mi,
                              input logic [3:0] de, input logic [3:0] dm,
                              input logic [63:0] ve, input logic [63:0] vm);
        logic was_halted;
        if (rst) begin
            for (int r = 0; r < 15; r++) m_regs[r] = (r == 4) ? RSP : 64'd0;
            m_wstat = 3'd0; m_wicode = 4'h1; m_wdste = 4'hF; m_wdstm = 4'hF;
            m_wvale = 0; m_wvalm = 0;
            m_stat = 3'd1; m_halted = 1'b0; m_retired = 0;
            return;
        end
        was_halted = m_halted;
        if (!was_halted) begin
            if (m_wstat == 3'd1) begin
                if (m_wdste != 4'hF) m_regs[m_wdste] = m_wvale;
                if (m_wdstm != 4'hF) m_regs[m_wdstm] = m_wvalm;
                m_retired = m_retired + 1;
            end else if (m_wstat != 3'd0) begin
                m_stat = (m_wstat == 3'd2 || m_wstat == 3'd3) ? m_wstat : 3'd4;
                m_halted = 1'b1;
            end
            if (!stall) begin
                if (bubble) begin
                    m_wstat = 3'd0; m_wicode = 4'h1; m_wdste = 4'hF; m_wdstm = 4'hF;
                    m_wvale = 0; m_wvalm = 0;
                end else begin
                    m_wstat = ms; m_wicode = mi; m_wdste = de; m_wdstm = dm;
                    m_wvale = ve; m_wvalm = vm;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model and the DUT together.
    task automatic apply(input logic rst, input logic stall, input logic bubble,
                         input logic [2:0] ms, input logic [3:0] mi,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [63:0] ve, input logic [63:0] vm);
        reset = rst; wbif.W_stall = stall; wbif.W_bubble = bubble;
        wbif.M_stat = ms; wbif.M_icode = mi; wbif.M_dstE = de; wbif.M_dstM = dm;
        wbif.M_valE = ve; wbif.m_valM = vm;
        model_step(rst, stall, bubble, ms, mi, de, dm, ve, vm);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_vs_model(input int cyc);
        for (int r = 0; r < 15; r++) check($sformatf("c%0d reg%0d", cyc, r), dut_regs[r], m_regs[r]);
        check($sformatf("c%0d W_stat", cyc),  64'(wbif.W_stat),  64'(m_wstat));
        check($sformatf("c%0d W_icode", cyc), 64'(wbif.W_icode), 64'(m_wicode));
        check($sformatf("c%0d W_dstE", cyc),  64'(wbif.W_dstE),  64'(m_wdste));
        check($sformatf("c%0d W_dstM", cyc),  64'(wbif.W_dstM),  64'(m_wdstm));
        check($sformatf("c%0d W_valE", cyc),  wbif.W_valE, m_wvale);
        check($sformatf("c%0d W_valM", cyc),  wbif.W_valM, m_wvalm);
        check($sformatf("c%0d stat", cyc),    64'(stat),   64'(m_stat));
        check($sformatf("c%0d halted", cyc),  64'(halted), 64'(m_halted));
        check($sformatf("c%0d retired", cyc), retired, m_retired);
    endtask

    typedef struct {
        logic        rst, stall, bubble;
        logic [2:0]  ms;
        logic [3:0]  de, dm;
        logic [63:0] ve, vm;
        int          chk_idx;
        logic [63:0] chk_val;
        logic [63:0] exp_ret;
        logic [2:0]  exp_stat;
        logic        exp_halt;
    } vec_t;

    function automatic vec_t mk(logic rst, logic stall, logic bubble, logic [2:0] ms,
                                logic [3:0] de, logic [3:0] dm, logic [63:0] ve, logic [63:0] vm,
                                int ci, logic [63:0] cv, logic [63:0] er, logic [2:0] es, logic eh);
        vec_t v;
        v.rst = rst; v.stall = stall; v.bubble = bubble; v.ms = ms;
        v.de = de; v.dm = dm; v.ve = ve; v.vm = vm;
        v.chk_idx = ci; v.chk_val = cv; v.exp_ret = er; v.exp_stat = es; v.exp_halt = eh;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        //            rst st bu ms    dstE  dstM  valE      valM     reg val      ret st    h
        vecs[0]  = mk(1, 0, 0, 3'd1, 4'hF, 4'hF, 64'h0,    64'h0,   4, 64'h100,  0, 3'd1, 0);
        vecs[1]  = mk(0, 0, 0, 3'd1, 4'h3, 4'hF, 64'h55,   64'h0,   3, 64'h0,    0, 3'd1, 0);
        vecs[2]  = mk(0, 0, 1, 3'd1, 4'hF, 4'hF, 64'h0,    64'h0,   3, 64'h55,   1, 3'd1, 0);
        vecs[3]  = mk(0, 0, 0, 3'd1, 4'h4, 4'h4, 64'h108,  64'hABC, 4, 64'h100,  1, 3'd1, 0);
        vecs[4]  = mk(0, 0, 1, 3'd1, 4'hF, 4'hF, 64'h0,    64'h0,   4, 64'hABC,  2, 3'd1, 0);
        vecs[5]  = mk(0, 0, 0, 3'd1, 4'h2, 4'hF, 64'h1,    64'h0,   2, 64'h0,    2, 3'd1, 0);
        vecs[6]  = mk(0, 0, 0, 3'd1, 4'h2, 4'hF, 64'h2,    64'h0,   2, 64'h1,    3, 3'd1, 0);
        vecs[7]  = mk(0, 1, 1, 3'd1, 4'h2, 4'hF, 64'h9,    64'h0,   2, 64'h2,    4, 3'd1, 0);
        vecs[8]  = mk(0, 0, 0, 3'd1, 4'h6, 4'hF, 64'h66,   64'h0,   2, 64'h2,    5, 3'd1, 0);
        vecs[9]  = mk(0, 0, 1, 3'd1, 4'hF, 4'hF, 64'h0,    64'h0,   6, 64'h66,   6, 3'd1, 0);
        vecs[10] = mk(0, 0, 0, 3'd1, 4'hF, 4'hF, 64'hFFFF, 64'h0,   0, 64'h0,    6, 3'd1, 0);
        vecs[11] = mk(0, 0, 1, 3'd1, 4'hF, 4'hF, 64'h0,    64'h0,   14, 64'h0,   7, 3'd1, 0);
        vecs[12] = mk(0, 0, 0, 3'd2, 4'h5, 4'hF, 64'h7,    64'h0,   5, 64'h0,    7, 3'd1, 0);
        vecs[13] = mk(0, 0, 0, 3'd1, 4'h5, 4'hF, 64'h9,    64'h0,   5, 64'h0,    7, 3'd2, 1);
        vecs[14] = mk(0, 0, 1, 3'd1, 4'h7, 4'hF, 64'h0,    64'h0,   5, 64'h0,    7, 3'd2, 1);
        vecs[15] = mk(1, 0, 0, 3'd1, 4'hF, 4'hF, 64'h0,    64'h0,   4, 64'h100,  0, 3'd1, 0);

        reset = 1'b1;
        wbif.W_stall = 0; wbif.W_bubble = 0; wbif.M_stat = 3'd0; wbif.M_icode = 4'h1;
        wbif.M_dstE = 4'hF; wbif.M_dstM = 4'hF; wbif.M_valE = 0; wbif.m_valM = 0;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].rst, vecs[i].stall, vecs[i].bubble, vecs[i].ms, 4'h6,
                  vecs[i].de, vecs[i].dm, vecs[i].ve, vecs[i].vm);
            $display("vec %0d: rst=%0d stall=%0d bubble=%0d stat_in=%0d dstE=%0h dstM=%0h -> reg%0d=0x%0h retired=%0d stat=%0d halted=%0d",
                     i, vecs[i].rst, vecs[i].stall, vecs[i].bubble, vecs[i].ms, vecs[i].de, vecs[i].dm,
                     vecs[i].chk_idx, dut_regs[vecs[i].chk_idx], retired, stat, halted);
            check($sformatf("vec%0d reg%0d", i, vecs[i].chk_idx), dut_regs[vecs[i].chk_idx], vecs[i].chk_val);
            check($sformatf("vec%0d retired", i), retired, vecs[i].exp_ret);
            check($sformatf("vec%0d stat", i), 64'(stat), 64'(vecs[i].exp_stat));
            check($sformatf("vec%0d halted", i), 64'(halted), 64'(vecs[i].exp_halt));
            // Multi-cycle corner cases observed on the W register itself.
            if (i == 0 || i == 15) begin
                check($sformatf("vec%0d reset W_stat", i),  64'(wbif.W_stat), 64'd0);
                check($sformatf("vec%0d reset W_icode", i), 64'(wbif.W_icode), 64'd1);
                check($sformatf("vec%0d reset W_dstE", i),  64'(wbif.W_dstE), 64'hF);
                check($sformatf("vec%0d reset W_dstM", i),  64'(wbif.W_dstM), 64'hF);
                check($sformatf("vec%0d reset W_valM", i),  wbif.W_valM, 64'd0);
            end
            if (i == 7) begin
                check("stall-beats-bubble W_valE", wbif.W_valE, 64'h2);
                check("stall-beats-bubble W_stat", 64'(wbif.W_stat), 64'd1);
            end
            if (i == 8) check("post-stall load W_dstE", 64'(wbif.W_dstE), 64'h6);
            if (i == 14) check("halt freezes W_valE", wbif.W_valE, 64'h9);
        end

        // Random traffic; occasional resets recover from halts.
        for (int c = 0; c < 400; c++) begin
            logic rst, st, bu;
            logic [2:0] ms;
            logic [3:0] de, dm;
            logic [63:0] ve, vm;
            rst = ($urandom_range(0, 39) == 0) || (halted && $urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 9) == 0);
            bu  = ($urandom_range(0, 9) == 0);
            ms  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            de  = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            dm  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            ve  = {$urandom, $urandom};
            vm  = {$urandom, $urandom};
            apply(rst, st, bu, ms, 4'($urandom_range(0, 15)), de, dm, ve, vm);
            $display("rnd %0d: rst=%0d stall=%0d bubble=%0d stat_in=%0d dstE=%0h dstM=%0h -> stat=%0d halted=%0d retired=%0d",
                     c, rst, st, bu, ms, de, dm, stat, halted, retired);
            check_all_vs_model(c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
